ip_multi_comparator: RTL and testbench

- Parametrised successor to the single-address IP comparator.
- Scans a big-endian 32-bit word stream for any of NUM_PATTERNS programmable 4-byte IP patterns, each with a per-byte mask. A pattern may start at any byte alignment and straddle two words.
- Passes the stream through a fixed 3-cycle delay. Flags match, winning pattern id, byte offset and per-pattern hit vector alongside the word that completes the match. Keeps a saturating match counter.
- Sits between the packet byte aligner and the flag/capture logic.

---
 rtl/ip_multi_comparator.sv | 185 ++++++++++++++++++
 tb/tb_ip_multi_comparator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_multi_comparator.sv
// ip_multi_comparator
// Scans a big-endian 32-bit word stream for any of NUM_PATTERNS masked 4-byte
// IP patterns at any byte alignment, including patterns that straddle two words.
// The stream passes through a fixed 3-cycle delay. Match flags, the winning slot,
// the byte offset and the per-slot hit vector are co-timed with the word that
// completes the match. A saturating counter tallies match cycles.
module ip_multi_comparator #(
    parameter int NUM_PATTERNS = 4,
    parameter int ID_W         = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    parameter int COUNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [31:0]             data_in,
    input  logic                    data_valid,
    input  logic                    cfg_wr,
    input  logic [ID_W-1:0]         cfg_idx,
    input  logic [31:0]             cfg_pattern,
    input  logic [3:0]              cfg_mask,
    input  logic                    cfg_en,
    output logic [31:0]             data_out,
    output logic                    data_out_valid,
    output logic                    match,
    output logic [ID_W-1:0]         match_id,
    output logic [1:0]              match_offset,
    output logic [NUM_PATTERNS-1:0] hit_mask,
    output logic [COUNT_W-1:0]      match_count
);

    // Pattern slot storage
    logic [31:0]             pat_q  [NUM_PATTERNS];
    logic [3:0]              mask_q [NUM_PATTERNS];
    logic [NUM_PATTERNS-1:0] en_q;

    // Window state: r_cur is the most recently accepted word, i.e. the
    // upper half of the 64-bit window formed when the next word arrives.
    logic [31:0] r_cur;
    logic        have_word;
    logic        accept;

    // Pipeline stages
    logic [NUM_PATTERNS-1:0][3:0] hit_d;
    logic [NUM_PATTERNS-1:0][3:0] hit_p0;
    logic [NUM_PATTERNS-1:0][3:0] hit_p1;
    logic [31:0]                  data_p0;
    logic [31:0]                  data_p1;
    logic                         vld_p0;
    logic                         vld_p1;

    // Encode results
    logic [NUM_PATTERNS-1:0] hm_d;
    logic [ID_W-1:0]         id_d;
    logic [1:0]              off_d;

    assign accept = data_valid & ~clear;

    // True when every enabled byte of the candidate at offset k equals the pattern
    function automatic logic slot_hit(input logic [63:0] win, input int k,
                                      input logic [31:0] pat, input logic [3:0] msk,
                                      input logic en);
        logic ok;
        ok = en;
        for (int b = 0; b < 4; b++) begin
            if (msk[3-b] && (win[63-8*(k+b) -: 8] != pat[31-8*b -: 8]))
                ok = 1'b0;
        end
        return ok;
    endfunction

    // Lowest offset set in a slot's hit row
    function automatic logic [1:0] lowest_off(input logic [3:0] row);
        logic [1:0] off;
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (row[k])
                off = 2'(k);
        end
        return off;
    endfunction

    // Saturating increment of the match counter
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    // Configuration writes; clear leaves slots untouched, out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                pat_q[i]  <= '0;
                mask_q[i] <= '0;
            end
            en_q <= '0;
        end else if (cfg_wr && (int'(cfg_idx) < NUM_PATTERNS)) begin
            pat_q[cfg_idx]  <= cfg_pattern;
            mask_q[cfg_idx] <= cfg_mask;
            en_q[cfg_idx]   <= cfg_en;
        end
    end

    // Compare the window {previous word, incoming word} against the slot values
    // held before this edge, so a concurrent cfg_wr only affects later windows
    always_comb begin
        hit_d = '0;
        if (accept && have_word) begin
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                for (int k = 0; k < 4; k++) begin
                    hit_d[i][k] = slot_hit({r_cur, data_in}, k, pat_q[i], mask_q[i], en_q[i]);
                end
            end
        end
    end

    // ---- stage p0: window update and hit-matrix capture ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cur     <= '0;
            have_word <= 1'b0;
            hit_p0    <= '0;
            data_p0   <= '0;
            vld_p0    <= 1'b0;
        end else begin
            hit_p0  <= hit_d;
            data_p0 <= data_in;
            vld_p0  <= data_valid;
            if (accept) begin
                r_cur     <= data_in;
                have_word <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered hit matrix ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hit_p1  <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            hit_p1  <= hit_p0;
            data_p1 <= data_p0;
            vld_p1  <= vld_p0;
        end
    end

    // Priority encode: lowest slot wins, then its lowest offset
    always_comb begin
        hm_d  = '0;
        id_d  = '0;
        off_d = 2'd0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            hm_d[i] = |hit_p1[i];
        end
        for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
            if (hm_d[i]) begin
                id_d  = ID_W'(i);
                off_d = lowest_off(hit_p1[i]);
            end
        end
    end

    // ---- stage p2: output registers and match counter ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            match          <= 1'b0;
            match_id       <= '0;
            match_offset   <= 2'd0;
            hit_mask       <= '0;
            match_count    <= '0;
        end else begin
            data_out       <= data_p1;
            data_out_valid <= vld_p1;
            match          <= |hm_d;
            match_id       <= id_d;
            match_offset   <= off_d;
            hit_mask       <= hm_d;
            if (|hm_d)
                match_count <= sat_inc(match_count);
        end
    end

endmodule

// File: tb/tb_ip_multi_comparator.sv
// Directed bench for ip_multi_comparator: each driven cycle pushes its expected
// output to a scoreboard queue, popped and compared three cycles later.
module tb_ip_multi_comparator;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   data_in = '0;
    logic          data_valid = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [31:0]   cfg_pattern = '0;
    logic [3:0]    cfg_mask = '0;
    logic          cfg_en = 1'b0;
    logic [31:0]   data_out;
    logic          data_out_valid;
    logic          match;
    logic [IW-1:0] match_id;
    logic [1:0]    match_offset;
    logic [NP-1:0] hit_mask;
    logic [CW-1:0] match_count;

    ip_multi_comparator #(.NUM_PATTERNS(NP), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .data_in(data_in), .data_valid(data_valid),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_en(cfg_en),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .match(match), .match_id(match_id), .match_offset(match_offset),
        .hit_mask(hit_mask), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic [31:0] data;
        logic        vld;
        logic        m;
        logic [1:0]  id;
        logic [1:0]  off;
        logic [3:0]  hm;
        bit          clr;
    } rec_t;

    rec_t q[$];
    int   evals   = 0;
    int   fails   = 0;
    int   step_no = 0;
    int   exp_cnt = 0;

    task automatic chk(input int s, input string name, input logic [31:0] got, input logic [31:0] exp);
        evals++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL step%0d %s observed %h expected %h", s, name, got, exp);
        end
    endtask

    task automatic check_rec(input rec_t r);
        if (r.clr) exp_cnt = 0;
        if (r.m) exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
        chk(r.step, "data_out",       data_out,              r.data);
        chk(r.step, "data_out_valid", {31'd0, data_out_valid}, {31'd0, r.vld});
        chk(r.step, "match",          {31'd0, match},          {31'd0, r.m});
        chk(r.step, "match_id",       {30'd0, match_id},       {30'd0, r.id});
        chk(r.step, "match_offset",   {30'd0, match_offset},   {30'd0, r.off});
        chk(r.step, "hit_mask",       {28'd0, hit_mask},       {28'd0, r.hm});
        chk(r.step, "match_count",    {30'd0, match_count},    32'(exp_cnt));
    endtask

    // One clock: drive inputs, queue the expectation, check the word from 3 cycles ago
    task automatic step(input logic [31:0] d, input logic v, input logic c,
                        input logic m, input logic [1:0] id, input logic [1:0] off,
                        input logic [3:0] hm);
        rec_t r;
        step_no++;
        data_in    = d;
        data_valid = v;
        clear      = c;
        r.step = step_no; r.data = d; r.vld = v; r.m = m;
        r.id = id; r.off = off; r.hm = hm; r.clr = 1'b0;
        if (c) begin
            foreach (q[i]) begin
                q[i].data = '0; q[i].vld = 1'b0; q[i].m = 1'b0;
                q[i].id = '0; q[i].off = '0; q[i].hm = '0; q[i].clr = 1'b1;
            end
            r.data = '0; r.vld = 1'b0; r.m = 1'b0;
            r.id = '0; r.off = '0; r.hm = '0; r.clr = 1'b1;
        end
        q.push_back(r);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        clear      = 1'b0;
        if (q.size() == 3) check_rec(q.pop_front());
    endtask

    task automatic word(input logic [31:0] d, input logic m, input logic [1:0] id,
                        input logic [1:0] off, input logic [3:0] hm);
        step(d, 1'b1, 1'b0, m, id, off, hm);
    endtask

    task automatic nomatch(input logic [31:0] d);
        step(d, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
    endtask

    task automatic do_clear();
        step(32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    endtask

    task automatic cfg_set(input logic [1:0] idx, input logic [31:0] pat,
                           input logic [3:0] msk, input logic en);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_pattern = pat; cfg_mask = msk; cfg_en = en;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] pat,
                             input logic [3:0] msk, input logic en);
        cfg_set(idx, pat, msk, en);
        idle(1);
        cfg_wr = 1'b0;
    endtask

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk(0, "rst data_out",       data_out,                  32'h0);
        chk(0, "rst data_out_valid", {31'd0, data_out_valid},   32'h0);
        chk(0, "rst match",          {31'd0, match},            32'h0);
        chk(0, "rst match_id",       {30'd0, match_id},         32'h0);
        chk(0, "rst match_offset",   {30'd0, match_offset},     32'h0);
        chk(0, "rst hit_mask",       {28'd0, hit_mask},         32'h0);
        chk(0, "rst match_count",    {30'd0, match_count},      32'h0);

        // All slots disabled: zero words never match
        nomatch(32'h00000000);
        nomatch(32'h00000000);
        idle(3);

        // Alignment sweep with slot 2
        cfg_write(2'd2, 32'hC0A80101, 4'hF, 1'b1);
        nomatch(32'hC0A80101);
        word(32'h00000000, 1'b1, 2'd2, 2'd0, 4'b0100);
        nomatch(32'h00C0A801);
        word(32'h01000000, 1'b1, 2'd2, 2'd1, 4'b0100);
        nomatch(32'h0000C0A8);
        word(32'h01010000, 1'b1, 2'd2, 2'd2, 4'b0100);
        nomatch(32'h000000C0);
        word(32'hA8010100, 1'b1, 2'd2, 2'd3, 4'b0100);
        idle(3);

        // Priority and masking
        cfg_write(2'd2, 32'h0, 4'h0, 1'b0);
        cfg_write(2'd0, 32'hC0A80100, 4'hE, 1'b1);
        cfg_write(2'd1, 32'hC0A80101, 4'hF, 1'b1);
        nomatch(32'hC0A80101);
        word(32'h00000000, 1'b1, 2'd0, 2'd0, 4'b0011);
        idle(3);

        // Idle gap inside a straddling match
        nomatch(32'h00C0A801);
        idle(5);
        word(32'h01000000, 1'b1, 2'd0, 2'd1, 4'b0011);
        idle(3);

        // Clear pulse between the two halves of a match
        nomatch(32'h00C0A801);
        do_clear();
        nomatch(32'h01000000);
        idle(3);

        // Word presented with clear is dropped
        nomatch(32'hC0A80101);
        step(32'h00C0A801, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
        nomatch(32'h01000000);
        idle(3);

        // Counter saturation with a mask-0 slot
        cfg_write(2'd0, 32'h0, 4'h0, 1'b1);
        do_clear();
        nomatch(32'h00000001);
        for (int i = 2; i <= 6; i++) word(32'(i), 1'b1, 2'd0, 2'd0, 4'b0001);
        idle(3);

        // Config write coinciding with word 2 does not affect that window
        cfg_write(2'd0, 32'h0, 4'h0, 1'b0);
        nomatch(32'h0A000001);
        cfg_set(2'd0, 32'h0A000001, 4'hF, 1'b1);
        nomatch(32'h0A000001);
        cfg_wr = 1'b0;
        word(32'h00000000, 1'b1, 2'd0, 2'd0, 4'b0001);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
